// File: rtl/renode_apb3_pkg.sv
// Shared types for the Renode APB3 completer bridge: FSM states and the
// request/response records exchanged with the Renode connection.
package renode_apb3_pkg;

  // Storage widths of the request/response records; bridge widths must not exceed them.
  localparam int ReqAddrWidth = 20;
  localparam int ReqDataWidth = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT,
    S_COMPLETE
  } state_t;

  typedef struct packed {
    logic                    write;
    logic [ReqAddrWidth-1:0] addr;
    logic [ReqDataWidth-1:0] data;
  } apb3_req_t;

  typedef struct packed {
    logic                    error;
    logic [ReqDataWidth-1:0] data;
  } apb3_rsp_t;

endpackage

// File: rtl/renode_apb3_completer_timer.sv
// Response watchdog for the Renode APB3 completer: counts cycles spent waiting on
// Renode and flags expiry once TimeoutCycles-1 is reached (count then holds).
module renode_apb3_completer_timer #(
  parameter int TimeoutCycles = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CountWidth = $clog2(TimeoutCycles + 1);

  logic [CountWidth-1:0] count_reg;

  assign expired = (count_reg == CountWidth'(TimeoutCycles - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_en && !expired) begin
      count_reg <= count_reg + CountWidth'(1);
    end
  end

endmodule

// File: rtl/renode_apb3_completer_bridge.sv
// APB3 completer that forwards each transfer to Renode as one valid/ready request
// and completes the access phase on the response. `define RENODE_APB3_TIMEOUT_EN adds a response timeout.
module renode_apb3_completer_bridge
  import renode_apb3_pkg::*;
#(
  parameter int AddressWidth  = 20,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AddressWidth-1:0] paddr,
  input  logic                    pselx,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DataWidth-1:0]    pwdata,
  output logic                    pready,
  output logic [DataWidth-1:0]    prdata,
  output logic                    pslverr,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_write,
  output logic [AddressWidth-1:0] req_addr,
  output logic [DataWidth-1:0]    req_wdata,
  input  logic                    rsp_valid,
  input  logic [DataWidth-1:0]    rsp_rdata,
  input  logic                    rsp_error
);

  state_t    state_reg;
  logic      late_pending_reg;
  logic      pready_reg;
  apb3_req_t req_reg;
  apb3_rsp_t rsp_reg;

  logic setup_seen;
  logic req_fire;
  logic timeout_hit;

  assign setup_seen = (state_reg == S_IDLE) && pselx && !penable;
  // An abandoned request still owes Renode a response; hold off the next one until it drains.
  assign req_valid  = (state_reg == S_REQUEST) && !late_pending_reg;
  assign req_fire   = req_valid && req_ready;

  assign req_write = req_reg.write;
  assign req_addr  = req_reg.addr[AddressWidth-1:0];
  assign req_wdata = req_reg.data[DataWidth-1:0];
  assign pready    = pready_reg;
  assign prdata    = rsp_reg.data[DataWidth-1:0];
  assign pslverr   = rsp_reg.error;

`ifdef RENODE_APB3_TIMEOUT_EN
  logic timer_expired;

  renode_apb3_completer_timer #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (setup_seen),
    .count_en((state_reg == S_REQUEST) || (state_reg == S_WAIT)),
    .expired (timer_expired)
  );

  assign timeout_hit = timer_expired;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TimeoutCycles == 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      late_pending_reg <= 1'b0;
      pready_reg       <= 1'b0;
      req_reg          <= '0;
      rsp_reg          <= '0;
    end else begin
      pready_reg <= 1'b0;
      rsp_reg    <= '0;
      case (state_reg)
        S_IDLE: begin
          if (rsp_valid) begin
            late_pending_reg <= 1'b0;
          end
          if (setup_seen) begin
            req_reg.write <= pwrite;
            req_reg.addr  <= ReqAddrWidth'(paddr);
            req_reg.data  <= pwrite ? ReqDataWidth'(pwdata) : '0;
            state_reg     <= S_REQUEST;
          end
        end
        S_REQUEST: begin
          if (rsp_valid && late_pending_reg) begin
            late_pending_reg <= 1'b0;
          end
          if (!pselx) begin
            state_reg <= S_IDLE;
            if (req_fire && !rsp_valid) begin
              late_pending_reg <= 1'b1;
            end
          end else if (req_fire && rsp_valid) begin
            state_reg     <= S_COMPLETE;
            pready_reg    <= 1'b1;
            rsp_reg.data  <= req_reg.write ? '0 : ReqDataWidth'(rsp_rdata);
            rsp_reg.error <= rsp_error;
          end else if (req_fire) begin
            state_reg <= S_WAIT;
          end else if (timeout_hit) begin
            state_reg     <= S_COMPLETE;
            pready_reg    <= 1'b1;
            rsp_reg.error <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!pselx) begin
            state_reg        <= S_IDLE;
            late_pending_reg <= !rsp_valid;
          end else if (rsp_valid) begin
            state_reg     <= S_COMPLETE;
            pready_reg    <= 1'b1;
            rsp_reg.data  <= req_reg.write ? '0 : ReqDataWidth'(rsp_rdata);
            rsp_reg.error <= rsp_error;
          end else if (timeout_hit) begin
            state_reg        <= S_COMPLETE;
            pready_reg       <= 1'b1;
            rsp_reg.error    <= 1'b1;
            late_pending_reg <= 1'b1;
          end
        end
        S_COMPLETE: begin
          if (rsp_valid) begin
            late_pending_reg <= 1'b0;
          end
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_renode_apb3_completer_bridge.sv
// Directed self-checking bench for renode_apb3_completer_bridge; the timeout
// scenario runs only when RENODE_APB3_TIMEOUT_EN is defined.
module tb_renode_apb3_completer_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] paddr = '0;
  logic        pselx = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic        req_write;
  logic [19:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_rdata = '0;
  logic        rsp_error = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  renode_apb3_completer_bridge #(
    .AddressWidth (20),
    .DataWidth    (32),
    .TimeoutCycles(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .paddr    (paddr),
    .pselx    (pselx),
    .penable  (penable),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .pready   (pready),
    .prdata   (prdata),
    .pslverr  (pslverr),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic wr, input logic [19:0] addr, input logic [31:0] data);
    pselx   = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
  endtask

  task automatic bus_idle();
    pselx     = 1'b0;
    penable   = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_error = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_idle();
    tick();
    tick();
    total++;
    if ({pready, pslverr, req_valid, req_write} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {pready, pslverr, req_valid, req_write});
    end
    total++;
    if (prdata !== 32'h0) begin
      bad++; $display("FAIL reset_prdata: got %h want 00000000", prdata);
    end
    total++;
    if ({req_addr, req_wdata} !== 52'h0) begin
      bad++; $display("FAIL reset_req_fields: got %h want 0", {req_addr, req_wdata});
    end
    rst = 1'b0;
    tick();
    $display("reset: done");
  endtask

  task automatic test_write();
    setup(1'b1, 20'h00100, 32'hDEADBEEF);
    req_ready = 1'b1;
    tick();
    total++;
    if ({req_valid, req_write, req_addr, req_wdata, pready} !== {1'b1, 1'b1, 20'h00100, 32'hDEADBEEF, 1'b0}) begin
      bad++; $display("FAIL wr_request: got v=%b w=%b a=%h d=%h rdy=%b want v=1 w=1 a=00100 d=deadbeef rdy=0",
                      req_valid, req_write, req_addr, req_wdata, pready);
    end
    penable = 1'b1;
    tick();
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({req_valid, pready} !== 2'b00) begin
        bad++; $display("FAIL wr_wait_%0d: got valid=%b pready=%b want 0 0", i, req_valid, pready);
      end
      if (i == 2) begin
        rsp_valid = 1'b1;
        rsp_rdata = 32'hAAAA5555;
      end
      tick();
    end
    rsp_valid = 1'b0;
    total++;
    if ({pready, pslverr, prdata} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL wr_complete: got pready=%b pslverr=%b prdata=%h want 1 0 00000000", pready, pslverr, prdata);
    end
    bus_idle();
    tick();
    total++;
    if (pready !== 1'b0) begin
      bad++; $display("FAIL wr_single_pulse: got pready=%b want 0", pready);
    end
    $display("write 0x100: done");
  endtask

  task automatic test_read_b2b();
    setup(1'b0, 20'h00204, 32'hFFFFFFFF);
    req_ready = 1'b1;
    tick();
    total++;
    if ({req_valid, req_write, req_addr, req_wdata} !== {1'b1, 1'b0, 20'h00204, 32'h0}) begin
      bad++; $display("FAIL rd_request: got v=%b w=%b a=%h d=%h want v=1 w=0 a=00204 d=00000000",
                      req_valid, req_write, req_addr, req_wdata);
    end
    penable   = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 32'h12345678;
    tick();
    rsp_valid = 1'b0;
    total++;
    if ({pready, pslverr, prdata} !== {1'b1, 1'b0, 32'h12345678}) begin
      bad++; $display("FAIL rd_complete: got pready=%b pslverr=%b prdata=%h want 1 0 12345678", pready, pslverr, prdata);
    end
    tick();
    total++;
    if ({pready, prdata} !== {1'b0, 32'h0}) begin
      bad++; $display("FAIL rd_after_complete: got pready=%b prdata=%h want 0 00000000", pready, prdata);
    end
    setup(1'b0, 20'h00208, 32'h0);
    tick();
    total++;
    if ({req_valid, req_addr} !== {1'b1, 20'h00208}) begin
      bad++; $display("FAIL b2b_request: got v=%b a=%h want v=1 a=00208", req_valid, req_addr);
    end
    penable   = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 32'hCAFEF00D;
    tick();
    total++;
    if ({pready, prdata} !== {1'b1, 32'hCAFEF00D}) begin
      bad++; $display("FAIL b2b_complete: got pready=%b prdata=%h want 1 cafef00d", pready, prdata);
    end
    bus_idle();
    tick();
    $display("read 0x204 + back-to-back 0x208: done");
  endtask

  task automatic test_error();
    setup(1'b0, 20'h00300, 32'h0);
    req_ready = 1'b1;
    tick();
    penable   = 1'b1;
    rsp_valid = 1'b1;
    rsp_error = 1'b1;
    rsp_rdata = 32'h12345678;
    tick();
    rsp_valid = 1'b0;
    rsp_error = 1'b0;
    total++;
    if ({pready, pslverr, prdata} !== {1'b1, 1'b1, 32'h12345678}) begin
      bad++; $display("FAIL err_complete: got pready=%b pslverr=%b prdata=%h want 1 1 12345678", pready, pslverr, prdata);
    end
    tick();
    setup(1'b0, 20'h00304, 32'h0);
    tick();
    penable   = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 32'h0BADF00D;
    tick();
    total++;
    if ({pready, pslverr, prdata} !== {1'b1, 1'b0, 32'h0BADF00D}) begin
      bad++; $display("FAIL err_next_clean: got pready=%b pslverr=%b prdata=%h want 1 0 0badf00d", pready, pslverr, prdata);
    end
    bus_idle();
    tick();
    $display("read error response: done");
  endtask

  task automatic test_backpressure();
    setup(1'b1, 20'h00040, 32'h55AA00FF);
    req_ready = 1'b0;
    tick();
    penable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({req_valid, req_write, req_addr, req_wdata, pready} !== {1'b1, 1'b1, 20'h00040, 32'h55AA00FF, 1'b0}) begin
        bad++; $display("FAIL bp_hold_%0d: got v=%b w=%b a=%h d=%h rdy=%b want v=1 w=1 a=00040 d=55aa00ff rdy=0",
                        i, req_valid, req_write, req_addr, req_wdata, pready);
      end
      if (i < 4) tick();
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    total++;
    if ({req_valid, pready} !== 2'b00) begin
      bad++; $display("FAIL bp_accepted: got valid=%b pready=%b want 0 0", req_valid, pready);
    end
    rsp_valid = 1'b1;
    rsp_rdata = 32'h00000077;
    tick();
    total++;
    if ({pready, pslverr, prdata} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL bp_complete: got pready=%b pslverr=%b prdata=%h want 1 0 00000000", pready, pslverr, prdata);
    end
    bus_idle();
    tick();
    $display("write with req_ready backpressure: done");
  endtask

  task automatic test_abort_late();
    // Abort while waiting, stale response arrives in idle, then a fresh read.
    setup(1'b0, 20'h00500, 32'h0);
    req_ready = 1'b1;
    tick();
    penable = 1'b1;
    tick();
    bus_idle();
    tick();
    total++;
    if ({pready, req_valid} !== 2'b00) begin
      bad++; $display("FAIL abort_idle: got pready=%b valid=%b want 0 0", pready, req_valid);
    end
    rsp_valid = 1'b1;
    rsp_rdata = 32'h11111111;
    tick();
    rsp_valid = 1'b0;
    total++;
    if (pready !== 1'b0) begin
      bad++; $display("FAIL abort_discard: got pready=%b want 0", pready);
    end
    setup(1'b0, 20'h00600, 32'h0);
    tick();
    total++;
    if ({req_valid, req_addr} !== {1'b1, 20'h00600}) begin
      bad++; $display("FAIL abort_new_req: got v=%b a=%h want v=1 a=00600", req_valid, req_addr);
    end
    penable   = 1'b1;
    req_ready = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 32'h22222222;
    tick();
    total++;
    if ({pready, prdata} !== {1'b1, 32'h22222222}) begin
      bad++; $display("FAIL abort_new_rsp: got pready=%b prdata=%h want 1 22222222", pready, prdata);
    end
    bus_idle();
    tick();
    // Abort while waiting, new read issued before the stale response drains.
    setup(1'b0, 20'h00510, 32'h0);
    req_ready = 1'b1;
    tick();
    penable = 1'b1;
    tick();
    bus_idle();
    tick();
    setup(1'b0, 20'h00610, 32'h0);
    tick();
    total++;
    if (req_valid !== 1'b0) begin
      bad++; $display("FAIL late_hold: got valid=%b want 0", req_valid);
    end
    penable   = 1'b1;
    req_ready = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 32'h33333333;
    tick();
    total++;
    if ({req_valid, pready} !== 2'b10) begin
      bad++; $display("FAIL late_drained: got valid=%b pready=%b want 1 0", req_valid, pready);
    end
    rsp_rdata = 32'h44444444;
    tick();
    total++;
    if ({pready, prdata} !== {1'b1, 32'h44444444}) begin
      bad++; $display("FAIL late_own_data: got pready=%b prdata=%h want 1 44444444", pready, prdata);
    end
    bus_idle();
    tick();
    $display("manager abort + late response: done");
  endtask

  task automatic test_no_setup();
    pselx   = 1'b1;
    penable = 1'b1;
    paddr   = 20'h00999;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({req_valid, pready} !== 2'b00) begin
        bad++; $display("FAIL no_setup_%0d: got valid=%b pready=%b want 0 0", i, req_valid, pready);
      end
    end
    bus_idle();
    tick();
    $display("access without setup ignored: done");
  endtask

`ifdef RENODE_APB3_TIMEOUT_EN
  task automatic test_timeout();
    setup(1'b0, 20'h00700, 32'h0);
    req_ready = 1'b1;
    tick();
    penable = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      total++;
      if (pready !== 1'b0) begin
        bad++; $display("FAIL to_early_%0d: got pready=%b want 0", i, pready);
      end
      tick();
      req_ready = 1'b0;
    end
    total++;
    if ({pready, pslverr, prdata} !== {1'b1, 1'b1, 32'h0}) begin
      bad++; $display("FAIL to_complete: got pready=%b pslverr=%b prdata=%h want 1 1 00000000", pready, pslverr, prdata);
    end
    bus_idle();
    rsp_valid = 1'b1;
    rsp_rdata = 32'h99999999;
    tick();
    rsp_valid = 1'b0;
    setup(1'b0, 20'h00704, 32'h0);
    tick();
    total++;
    if (req_valid !== 1'b1) begin
      bad++; $display("FAIL to_late_cleared: got valid=%b want 1", req_valid);
    end
    penable   = 1'b1;
    req_ready = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 32'h5A5A5A5A;
    tick();
    total++;
    if ({pready, pslverr, prdata} !== {1'b1, 1'b0, 32'h5A5A5A5A}) begin
      bad++; $display("FAIL to_next_read: got pready=%b pslverr=%b prdata=%h want 1 0 5a5a5a5a", pready, pslverr, prdata);
    end
    bus_idle();
    tick();
    $display("response timeout: done");
  endtask
`endif

  task automatic test_reset_mid();
    setup(1'b1, 20'h00800, 32'h01020304);
    req_ready = 1'b0;
    tick();
    penable = 1'b1;
    total++;
    if (req_valid !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre: got valid=%b want 1", req_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({req_valid, req_write, req_addr, req_wdata} !== 54'h0) begin
      bad++; $display("FAIL rstmid_async: got v=%b w=%b a=%h d=%h want all 0", req_valid, req_write, req_addr, req_wdata);
    end
    bus_idle();
    tick();
    rst = 1'b0;
    tick();
    setup(1'b0, 20'h00804, 32'h0);
    tick();
    penable   = 1'b1;
    req_ready = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 32'h0F0F0F0F;
    tick();
    total++;
    if ({pready, prdata} !== {1'b1, 32'h0F0F0F0F}) begin
      bad++; $display("FAIL rstmid_recover: got pready=%b prdata=%h want 1 0f0f0f0f", pready, prdata);
    end
    bus_idle();
    tick();
    $display("reset mid-transfer: done");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_b2b();
    test_error();
    test_backpressure();
    test_abort_late();
    test_no_setup();
`ifdef RENODE_APB3_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
